seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
- Downstream consumer of the 21-bit one-hot rotating position produced by the LED timer stage.
- Decodes the position to an index 0..20 and counts completed rotations.
- Drives an 8-digit, active-low, multiplexed 7-segment display:
  - Digits 1:0 show the index in decimal.
  - Digits 7:4 show the rotation count.
  - Digits 3:2 are always blank.
- Sits between the timer stage and the board display pins.

Parameters:
- SCAN_DIV, 100000: clock cycles each digit stays enabled (1 kHz per digit at 100 MHz); legal range ≥2.
- WRAP_DIGITS, 4: BCD digits in the rotation counter; fixed 4, shown on digits 7:4.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- pos_in  input  21  one-hot position from the timer stage; bit k set means index k.
- led_en  output  8  digit enables, active-low; bit n drives digit n.
- seg  output  8  segment drives, active-low, ordered {dp,g,f,e,d,c,b,a}.
- pos_err  output  1  high while the sampled position is not exactly one-hot.

Behaviour:
- One clock domain; reset is synchronous and active-high. Port names are clk and rst.
- Reset values:
  - Registers: pos_q=21'h000001; pos_d=21'h000001; idx=0; wrap_bcd=16'h0000; scan_cnt=0; digit_sel=0.
  - Outputs: led_en=8'hFF (all off); seg=8'hFF; pos_err=0.
- Sampling: pos_q<=pos_in every cycle; pos_d<=pos_q.
- Valid means popcount(pos_q)==1.
- idx (5 bits) is registered from pos_q, so idx reflects pos_in with 2-cycle latency.
- Invalid position handling:
  - pos_err is registered in the same cycle as idx; idx holds its last value.
  - Digits 1:0 display dash (8'hBF) while pos_err=1.
- BCD of idx: tens = 2 if idx≥20, 1 if idx≥10, else 0; ones = idx − 10*tens.
- Wrap detect:
  - Condition: pos_d[20]=1, pos_q[0]=1, and pos_q valid.
  - Effect: wrap_bcd increments by 1 with decimal carry (0009→0010, 9999→0000).
  - Exactly one increment per detected transition. No increment on invalid samples or any other transition.
- Scan timing:
  - scan_cnt counts 0..SCAN_DIV−1.
  - At the terminal count: scan_cnt→0, digit_sel←(digit_sel+1) mod 8, and led_en/seg are both reloaded on that same edge.
- Output encoding on reload:
  - led_en = ~(1<<digit_sel_next).
  - seg = glyph of the selected digit.
  - Glyph table: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF, dash=BF. dp is always off.
- Digit map:
  - digit 0 = ones of idx; digit 1 = tens of idx.
  - digits 3:2 = blank.
  - digit 4 = wrap_bcd[3:0] … digit 7 = wrap_bcd[15:12].
- First reload happens SCAN_DIV cycles after reset release, enabling digit 1. digit_sel=0 is re-entered every 8 slots.
- No glitching: led_en and seg never change on different edges, and each is exactly one register stage.
- Reset mid-scan or mid-wrap: everything returns to reset values on the next edge; a pending wrap is discarded.

Optional Feature:
- Macro SEG_ZERO_BLANK_EN.
- Defined:
  - Leading zeros blank: digit 1 is blank when tens=0.
  - Digits 7..5 are blank while all higher wrap digits and the digit itself are 0.
  - Digit 4 is always shown.
- Undefined: all eight digits except 3:2 always show numerals, including leading zeros.

Test Plan:
All scenarios use SCAN_DIV=4.
- Reset release with pos_in=21'h1:
  - led_en=FF and seg=FF for 4 cycles, then led_en=FD with digit 1 showing '0' (C0), or FF with SEG_ZERO_BLANK_EN.
  - Continued scan: digit 0 shows C0; digits 4–7 show C0 (no macro).
- pos_in=21'h000800 (index 11) held → on the slots for digit 1 and digit 0, seg=F9 for both; pos_err=0.
- Rotate pos_in through bit 20 → bit 0 three times → wrap_bcd=0003; digit 4 slot shows B0; no increment on bit 19→20.
- Preload 9999 wraps (force or 9999 rotations) then one more wrap → digits 7:4 show 0000; no carry out.
- pos_in=21'h000003 then 21'h0 → pos_err=1 two cycles later; digits 1:0 show BF; wrap count unchanged; recovery to one-hot clears pos_err.
- Assert rst mid-slot with wrap_bcd=0005 → next edge: led_en=FF, seg=FF, wrap_bcd=0, scan restarts from digit_sel=0.

Source files
------------

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Consumes the 21-bit one-hot rotating position from the LED timer stage,
//   decodes it to an index 0..20, counts completed rotations in BCD and
//   drives an 8-digit active-low multiplexed 7-segment display.
//     digits 1:0 : index in decimal (dash while the position is not one-hot)
//     digits 3:2 : always blank
//     digits 7:4 : rotation count, 4 BCD digits
//   Optional build macro SEG_ZERO_BLANK_EN: blank leading zeros (digit 1 when
//   tens is 0, digits 7..5 while they and all higher wrap digits are 0;
//   digit 4 always shown). Undefined: all numeric digits always shown.
// Ports
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   pos_in  : one-hot position, bit k means index k
//   led_en  : digit enables, active-low, bit n drives digit n
//   seg     : segments, active-low, {dp,g,f,e,d,c,b,a}
//   pos_err : high while the sampled position is not exactly one-hot
module seg_scan_display #(
  parameter int SCAN_DIV    = 100000,
  parameter int WRAP_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [20:0] pos_in,
  output logic [7:0]  led_en,
  output logic [7:0]  seg,
  output logic        pos_err
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int WW = 4 * WRAP_DIGITS;
`ifdef SEG_ZERO_BLANK_EN
  localparam bit ZERO_BLANK = 1'b1;
`else
  localparam bit ZERO_BLANK = 1'b0;
`endif

  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_DASH  = 8'hBF;

  logic [20:0]   pos_q, pos_d;
  logic [4:0]    idx;
  logic [WW-1:0] wrap_bcd;
  logic [CW-1:0] scan_cnt;
  logic [2:0]    digit_sel;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return GLYPH_BLANK;
    endcase
  endfunction

  function automatic logic [4:0] onehot_idx(input logic [20:0] v);
    logic [4:0] r;
    r = '0;
    for (int k = 0; k < 21; k++)
      if (v[k]) r = 5'(k);
    return r;
  endfunction

  // Decimal increment; the carry out of the top digit is dropped (9999 -> 0000).
  function automatic logic [WW-1:0] bcd_inc(input logic [WW-1:0] v);
    logic [WW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < WRAP_DIGITS; k++) begin
      if (c) begin
        if (r[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = r[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic       pos_valid;
  logic       wrap_hit;
  logic       scan_tc;
  logic [2:0] sel_n;
  logic [3:0] tens, ones;
  logic [3:0] wrap_digit;
  logic       wrap_lead_zero;
  logic [7:0] glyph_n;

  assign pos_valid = ($countones(pos_q) == 1);
  // pos_q valid with bit 0 set means pos_q is exactly bit 0.
  assign wrap_hit  = pos_d[20] && pos_q[0] && pos_valid;
  assign scan_tc   = (scan_cnt == CW'(SCAN_DIV - 1));
  assign sel_n     = digit_sel + 3'd1;

  always_comb begin
    tens = 4'd0;
    ones = 4'(idx);
    if (idx >= 5'd20) begin
      tens = 4'd2;
      ones = 4'(idx - 5'd20);
    end else if (idx >= 5'd10) begin
      tens = 4'd1;
      ones = 4'(idx - 5'd10);
    end
  end

  // Digits 7:4 map to wrap digits 3:0 through the low two bits of sel_n.
  // A wrap digit is a leading zero when it and every higher digit are 0.
  assign wrap_digit     = wrap_bcd[{sel_n[1:0], 2'b00} +: 4];
  assign wrap_lead_zero = ((wrap_bcd >> {sel_n[1:0], 2'b00}) == '0);

  always_comb begin
    glyph_n = GLYPH_BLANK;
    case (sel_n)
      3'd0: glyph_n = pos_err ? GLYPH_DASH : glyph(ones);
      3'd1: begin
        if (pos_err)                         glyph_n = GLYPH_DASH;
        else if (ZERO_BLANK && tens == 4'd0) glyph_n = GLYPH_BLANK;
        else                                 glyph_n = glyph(tens);
      end
      3'd2, 3'd3: glyph_n = GLYPH_BLANK;
      3'd4: glyph_n = glyph(wrap_digit);
      default: begin
        if (ZERO_BLANK && wrap_lead_zero) glyph_n = GLYPH_BLANK;
        else                              glyph_n = glyph(wrap_digit);
      end
    endcase
  end

  // Position pipeline, index decode and rotation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q    <= 21'h000001;
      pos_d    <= 21'h000001;
      idx      <= 5'd0;
      pos_err  <= 1'b0;
      wrap_bcd <= '0;
    end else begin
      pos_q   <= pos_in;
      pos_d   <= pos_q;
      pos_err <= !pos_valid;
      if (pos_valid) idx <= onehot_idx(pos_q);
      if (wrap_hit)  wrap_bcd <= bcd_inc(wrap_bcd);
    end
  end

  // Scan: led_en and seg reload together on the terminal count so they
  // never change on different edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt  <= '0;
      digit_sel <= 3'd0;
      led_en    <= 8'hFF;
      seg       <= 8'hFF;
    end else if (scan_tc) begin
      scan_cnt  <= '0;
      digit_sel <= sel_n;
      led_en    <= ~(8'h01 << sel_n);
      seg       <= glyph_n;
    end else begin
      scan_cnt  <= scan_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [20:0] pos_in = 21'h000001;
  logic [7:0]  led_en, seg;
  logic        pos_err;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  seg_scan_display #(.SCAN_DIV(SD), .WRAP_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .pos_in(pos_in),
    .led_en(led_en), .seg(seg), .pos_err(pos_err)
  );

  // ---------------- behavioural model ----------------
  // Position history, decoded index, rotation count as a plain integer,
  // and the display slot derived from the number of edges since reset.
  logic [20:0] h1 = 21'h1, h2 = 21'h1;
  int          m_idx = 0, m_wrap = 0, n_edge = 0;
  logic        m_err = 1'b0;
  logic [7:0]  m_led = 8'hFF, m_seg = 8'hFF;
  bit          started = 1'b0;

  function automatic logic [7:0] glyph_of(int v);
    case (v)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; 9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int pow10(int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [7:0] model_digit(int d);
    int k;
    if (d == 0) return m_err ? 8'hBF : glyph_of(m_idx % 10);
    if (d == 1) begin
      if (m_err) return 8'hBF;
`ifdef SEG_ZERO_BLANK_EN
      if (m_idx / 10 == 0) return 8'hFF;
`endif
      return glyph_of(m_idx / 10);
    end
    if (d < 4) return 8'hFF;
    k = d - 4;
`ifdef SEG_ZERO_BLANK_EN
    if (k > 0 && m_wrap / pow10(k) == 0) return 8'hFF;
`endif
    return glyph_of((m_wrap / pow10(k)) % 10);
  endfunction

  function automatic int index_of(logic [20:0] v);
    for (int k = 0; k < 21; k++) if (v[k]) return k;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      h1 = 21'h1; h2 = 21'h1;
      m_idx = 0; m_wrap = 0; m_err = 1'b0; n_edge = 0;
      m_led = 8'hFF; m_seg = 8'hFF;
      started = 1'b1;
    end else begin
      n_edge++;
      if (n_edge % SD == 0) begin
        m_led = ~(8'h01 << ((n_edge / SD) % 8));
        m_seg = model_digit((n_edge / SD) % 8);
      end
      if ($countones(h1) == 1) begin
        m_err = 1'b0;
        m_idx = index_of(h1);
        if (h2[20] && h1[0]) m_wrap = (m_wrap + 1) % 10000;
      end else begin
        m_err = 1'b1;
      end
      h2 = h1;
      h1 = pos_in;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check8("led_en", led_en, m_led);
      check8("seg", seg, m_seg);
      check8("pos_err", {7'd0, pos_err}, {7'd0, m_err});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [20:0] p);
    @(negedge clk);
    pos_in = p;
  endtask

  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask

  // Waits for the display to newly enter digit d, then checks its glyph.
  task automatic expect_slot(input int d, input logic [7:0] exp, input string name);
    logic [7:0] tgt;
    logic [7:0] prev;
    bit ok = 1'b0;
    tgt = ~(8'h01 << d);
    prev = led_en;
    for (int c = 0; c < 80 && !ok; c++) begin
      @(negedge clk);
      if (led_en == tgt && prev != tgt) ok = 1'b1;
      prev = led_en;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: digit %0d slot not reached, led_en %h expected %h", name, d, led_en, tgt);
    end else begin
      check8(name, seg, exp);
    end
  endtask

  logic [7:0] lead_c0;
  initial begin
`ifdef SEG_ZERO_BLANK_EN
    lead_c0 = 8'hFF;
`else
    lead_c0 = 8'hC0;
`endif
  end

  // ---------------- stimulus ----------------
  initial begin
    int cur;
    rst = 1'b1;
    pos_in = 21'h1;
    idle(3);
    rst = 1'b0;

    // Reset release: blank for the first slot, then digit 1.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check8("rel_led_blank", led_en, 8'hFF);
      check8("rel_seg_blank", seg, 8'hFF);
    end
    @(negedge clk);
    check8("rel_first_led", led_en, 8'hFD);
    check8("rel_first_seg", seg, lead_c0);
    expect_slot(0, 8'hC0, "rel_d0");
    expect_slot(4, 8'hC0, "rel_d4");
    expect_slot(5, lead_c0, "rel_d5");
    expect_slot(6, lead_c0, "rel_d6");
    expect_slot(7, lead_c0, "rel_d7");

    // Index 11 shows "11".
    step(21'h000800);
    idle(3);
    expect_slot(1, 8'hF9, "idx11_d1");
    expect_slot(0, 8'hF9, "idx11_d0");
    check8("idx11_err", {7'd0, pos_err}, 8'h00);

    // Three rotations through 20 -> 0.
    step(21'h1);
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k < 21; k++) step(21'h1 << k);
      step(21'h1);
    end
    idle(3);
    expect_slot(4, 8'hB0, "wrap3_d4");

    // Not one-hot: multi-bit then zero.
    step(21'h000003);
    step(21'h000000);
    @(negedge clk);
    check8("err_set", {7'd0, pos_err}, 8'h01);
    expect_slot(0, 8'hBF, "err_d0");
    expect_slot(1, 8'hBF, "err_d1");
    expect_slot(4, 8'hB0, "err_wrap_kept");
    step(21'h1 << 5);
    idle(3);
    check8("err_clear", {7'd0, pos_err}, 8'h00);

    // Fast wraps (20 -> 0 pairs) up to 9999, then roll over to 0000.
    for (int i = 0; i < 9996; i++) begin
      step(21'h1 << 20);
      step(21'h1);
    end
    idle(3);
    expect_slot(7, 8'h90, "w9999_d7");
    step(21'h1 << 20);
    step(21'h1);
    idle(3);
    expect_slot(4, 8'hC0, "roll_d4");
    expect_slot(5, lead_c0, "roll_d5");
    expect_slot(6, lead_c0, "roll_d6");
    expect_slot(7, lead_c0, "roll_d7");

    // Five more wraps, then reset mid-slot.
    for (int i = 0; i < 5; i++) begin
      step(21'h1 << 20);
      step(21'h1);
    end
    step(21'h1 << 7);
    idle(3);
    expect_slot(4, 8'h92, "w5_d4");
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    check8("rst_led", led_en, 8'hFF);
    check8("rst_seg", seg, 8'hFF);
    check8("rst_err", {7'd0, pos_err}, 8'h00);
    rst = 1'b0;
    idle(3);
    @(negedge clk);
    check8("rst_restart_led", led_en, 8'hFD);
    expect_slot(4, 8'hC0, "rst_wrap_zero");

    // Randomized traffic checked by the model every cycle.
    cur = 7;
    for (int i = 0; i < 3000; i++) begin
      int m;
      m = $urandom_range(0, 9);
      if (m < 6)      begin cur = (cur + 1) % 21; step(21'h1 << cur); end
      else if (m < 8) begin cur = $urandom_range(0, 20); step(21'h1 << cur); end
      else if (m < 9) step(pos_in);
      else            step(21'($urandom()));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
